phys_free_list: RTL

// - Circular free list of physical register tags. It sits on the other side of the rename map table.
// - Rename pulls free tags from it and writes them into the map table.
// - Commit returns the freed old tags (the previous mappings) to it.
// - It keeps a speculative head and a committed head, so a pipeline flush restores every tag allocated after the last commit.

---
 rtl/rename_pkg.sv | 12 +
 rtl/phys_free_list_prefix_popcount.sv | 22 ++
 rtl/phys_free_list.sv | 107 ++++++++++
 3 files changed

// File: rtl/rename_pkg.sv
// Shared rename-stage sizing and tag/pointer types, used by the free list and the map table.
package rename_pkg;

    localparam int PHYS_COUNT      = 128;
    localparam int PHYS_ADDR_WIDTH = $clog2(PHYS_COUNT);
    localparam int ARCH_COUNT      = 32;
    localparam int PTR_WIDTH       = PHYS_ADDR_WIDTH + 1;

    typedef logic [PHYS_ADDR_WIDTH-1:0] phys_tag_t;
    typedef logic [PTR_WIDTH-1:0]       ptr_t;

endpackage

// File: rtl/phys_free_list_prefix_popcount.sv
// Exclusive prefix population count per bit, plus the total count of set bits.
module prefix_popcount #(
    parameter int  N  = 4,
    localparam int CW = $clog2(N + 1)
) (
    input  logic [N-1:0]    bits,
    output logic [N*CW-1:0] prefix,
    output logic [CW-1:0]   total
);

    always_comb begin
        logic [CW-1:0] acc;
        acc    = '0;
        prefix = '0;
        for (int i = 0; i < N; i++) begin
            prefix[i*CW +: CW] = acc;
            acc = acc + CW'(bits[i]);
        end
        total = acc;
    end

endmodule

// File: rtl/phys_free_list.sv
// Circular free list of physical tags with a speculative head (rename) and a
// committed head (retire), so a flush hands back everything allocated since the last commit.
module phys_free_list
    import rename_pkg::*;
#(
    parameter int ALLOC_PORTS = 4,
    parameter int REL_PORTS   = 4,
    parameter bit DUP_CHECK   = 1'b0
) (
    input  logic                                   clk,
    input  logic                                   sync_rst_n,
    input  logic                                   clk_en,
    input  logic [ALLOC_PORTS-1:0]                 alloc_req,
    output logic                                   alloc_grant,
    output logic [ALLOC_PORTS*PHYS_ADDR_WIDTH-1:0] alloc_phys_addr,
    input  logic [$clog2(ALLOC_PORTS+1)-1:0]       commit_cnt,
    input  logic [REL_PORTS-1:0]                   rel_en,
    input  logic [REL_PORTS*PHYS_ADDR_WIDTH-1:0]   rel_phys_addr,
    input  logic                                   flush,
    output logic [PTR_WIDTH-1:0]                   free_count,
    output logic                                   empty
);

    localparam int ACW = $clog2(ALLOC_PORTS + 1);
    localparam int RCW = $clog2(REL_PORTS + 1);
    localparam int PAW = PHYS_ADDR_WIDTH;

    phys_tag_t entries [PHYS_COUNT];
    ptr_t      spec_head;
    ptr_t      cmt_head;
    ptr_t      tail;

    logic [ALLOC_PORTS*ACW-1:0] alloc_prefix;
    logic [ACW-1:0]             alloc_total;
    logic [REL_PORTS*RCW-1:0]   rel_prefix;
    logic [RCW-1:0]             rel_total;

    phys_tag_t alloc_idx [ALLOC_PORTS];
    phys_tag_t rel_idx   [REL_PORTS];
    logic [REL_PORTS-1:0] rel_zero;

    prefix_popcount #(.N(ALLOC_PORTS)) u_alloc_count (
        .bits   (alloc_req),
        .prefix (alloc_prefix),
        .total  (alloc_total)
    );

    prefix_popcount #(.N(REL_PORTS)) u_rel_count (
        .bits   (rel_en),
        .prefix (rel_prefix),
        .total  (rel_total)
    );

    assign free_count  = tail - spec_head;
    assign empty       = (free_count == '0);
    assign alloc_grant = (|alloc_req) && (ptr_t'(alloc_total) <= free_count) && !flush;

    // Index arithmetic is done on the low pointer bits only, so wrap is free.
    always_comb begin
        alloc_phys_addr = '0;
        for (int i = 0; i < ALLOC_PORTS; i++) begin
            alloc_idx[i] = spec_head[PAW-1:0] + phys_tag_t'(alloc_prefix[i*ACW +: ACW]);
            alloc_phys_addr[i*PAW +: PAW] = entries[alloc_idx[i]];
        end
        for (int j = 0; j < REL_PORTS; j++) begin
            rel_idx[j]  = tail[PAW-1:0] + phys_tag_t'(rel_prefix[j*RCW +: RCW]);
            rel_zero[j] = rel_en[j] && (rel_phys_addr[j*PAW +: PAW] == '0);
        end
    end

    always_ff @(posedge clk or negedge sync_rst_n) begin
        if (!sync_rst_n) begin
            spec_head <= '0;
            cmt_head  <= '0;
            tail      <= ptr_t'(PHYS_COUNT - ARCH_COUNT);
        end else if (clk_en) begin
            cmt_head <= cmt_head + ptr_t'(commit_cnt);
            tail     <= tail + ptr_t'(rel_total);
            // Same-cycle commits are folded into the rollback target.
            if (flush)
                spec_head <= cmt_head + ptr_t'(commit_cnt);
            else if (alloc_grant)
                spec_head <= spec_head + ptr_t'(alloc_total);
        end
    end

    always_ff @(posedge clk or negedge sync_rst_n) begin
        if (!sync_rst_n) begin
            for (int i = 0; i < PHYS_COUNT; i++)
                entries[i] <= (i < PHYS_COUNT - ARCH_COUNT) ? phys_tag_t'(ARCH_COUNT + i) : '0;
        end else if (clk_en) begin
            for (int j = 0; j < REL_PORTS; j++)
                if (rel_en[j])
                    entries[rel_idx[j]] <= rel_phys_addr[j*PAW +: PAW];
        end
    end

    assert property (@(posedge clk) disable iff (!sync_rst_n)
        clk_en |-> (int'(free_count) + int'(rel_total) <= PHYS_COUNT));

    assert property (@(posedge clk) disable iff (!sync_rst_n)
        clk_en |-> (ptr_t'(commit_cnt) <= ptr_t'(spec_head - cmt_head)));

    assert property (@(posedge clk) disable iff (!sync_rst_n)
        !DUP_CHECK || (rel_zero == '0));

endmodule
